// File: rtl/axis_pacer_pkg.sv
// Shared defaults for the AXI-Stream pacer and its tick generator.
package axis_pacer_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_CWIDTH = 28;
    localparam int DEF_BURST  = 4;

endpackage

// File: rtl/axis_pacer_tick.sv
// Credit tick generator: a free-running timer that pulses once every
// effective period, where a period of 0 behaves like 1.
module pacer_tick
    import axis_pacer_pkg::*;
#(
    parameter int CWIDTH = DEF_CWIDTH
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [CWIDTH-1:0] period,
    output logic              tick
);

    logic [CWIDTH-1:0] r_timer;
    logic [CWIDTH-1:0] w_periodM1;
    logic              w_tick;

    // Last timer value of a period; a zero period clamps to a one-cycle period.
    assign w_periodM1 = (period == '0) ? '0 : period - CWIDTH'(1);

    // Compare with >= so that lowering the period mid-count ticks on the next edge.
    assign w_tick = (r_timer >= w_periodM1);
    assign tick   = w_tick;

    // Timer counts up and wraps to zero on every tick.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_timer <= '0;
        end else if (w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + CWIDTH'(1);
        end
    end

endmodule

// File: rtl/axis_pacer.sv
// Token-bucket rate limiter for a valid/ready stream with a registered
// output stage: up to BURST words pass back-to-back, then one word per period.
module axis_pacer
    import axis_pacer_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int CWIDTH = DEF_CWIDTH,
    parameter  int BURST  = DEF_BURST,
    localparam int KWIDTH = $clog2(BURST + 1)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [CWIDTH-1:0] period,
    input  logic              enable,
    input  logic [WIDTH-1:0]  idata,
    input  logic              ivalid,
    output logic              iready,
    output logic [WIDTH-1:0]  odata,
    output logic              ovalid,
    input  logic              oready,
    output logic [KWIDTH-1:0] credits
);

    localparam logic [KWIDTH:0] BURST_WIDE = (KWIDTH + 1)'(BURST);

    logic              w_tick;
    logic              w_iready;
    logic              w_accept;
    logic [KWIDTH:0]   w_creditSum;
    logic [KWIDTH-1:0] w_creditNext;
    logic [KWIDTH-1:0] r_credits;
    logic [WIDTH-1:0]  r_odata;
    logic              r_ovalid;

    pacer_tick #(
        .CWIDTH (CWIDTH)
    ) u_tick (
        .clock  (clock),
        .resetn (resetn),
        .period (period),
        .tick   (w_tick)
    );

    // Ready needs a credit and a free (or draining) output register; ivalid never feeds back.
    assign w_iready = enable && (r_credits != '0) && (!r_ovalid || oready);
    assign w_accept = ivalid && w_iready;

    // Credit count gains one on a tick, loses one per accepted word, and saturates at BURST.
    always_comb begin
        w_creditSum = {1'b0, r_credits}
                    + {{KWIDTH{1'b0}}, w_tick}
                    - {{KWIDTH{1'b0}}, w_accept};
        if (w_creditSum > BURST_WIDE) begin
            w_creditNext = BURST_WIDE[KWIDTH-1:0];
        end else begin
            w_creditNext = w_creditSum[KWIDTH-1:0];
        end
    end

    // Credits start full so the first burst passes immediately after reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_credits <= BURST_WIDE[KWIDTH-1:0];
        end else begin
            r_credits <= w_creditNext;
        end
    end

    // Output register loads on accept and empties when the sink takes the word; data holds otherwise.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ovalid <= 1'b0;
            r_odata  <= '0;
        end else if (w_accept) begin
            r_ovalid <= 1'b1;
            r_odata  <= idata;
        end else if (r_ovalid && oready) begin
            r_ovalid <= 1'b0;
        end
    end

    assign iready  = w_iready;
    assign odata   = r_odata;
    assign ovalid  = r_ovalid;
    assign credits = r_credits;

endmodule
